btn_reset_ctrl: RTL and testbench

BTN_RESET_CTRL -- requirements
Module: btn_reset_ctrl

---
 rtl/btn_reset_ctrl.sv | 134 +++++++++++++
 tb/tb_btn_reset_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/btn_reset_ctrl.sv
// Button-driven LED mode selector and bootloader reset requester for a 48 MHz board.
// Define BTN_CTRL_SYNC2_EN to put a two-flop synchronizer in front of the debouncer.
module btn_reset_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES  = 480000,
  parameter int unsigned HOLD_CYCLES      = 96000000,
  parameter int unsigned RST_PULSE_CYCLES = 4800
) (
  input  logic       clk48,
  input  logic       rst,
  input  logic       usr_btn,
  output logic       rgb_led0_r,
  output logic       rgb_led0_g,
  output logic       rgb_led0_b,
  output logic       rst_n,
  output logic [1:0] mode
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned PW = $clog2(RST_PULSE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic [PW-1:0] PULSE_LAST = PW'(RST_PULSE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HELD, ARMED, RESET} state_t;

  state_t        state, state_nx;
  logic [1:0]    mode_nx;
  logic [26:0]   blink_cnt;
  logic [DW-1:0] db_cnt;
  logic [HW-1:0] hold_cnt;
  logic [PW-1:0] pulse_cnt;
  logic          btn_sample;
  logic          btn_filt;
  logic          pressed;

`ifdef BTN_CTRL_SYNC2_EN
  logic sync1, sync2;
  always_ff @(posedge clk48 or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= usr_btn;
      sync2 <= sync1;
    end
  end
  assign btn_sample = sync2;
`else
  logic sync1;
  always_ff @(posedge clk48 or posedge rst) begin
    if (rst) sync1 <= 1'b1;
    else     sync1 <= usr_btn;
  end
  assign btn_sample = sync1;
`endif

  always_ff @(posedge clk48 or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      db_cnt    <= '0;
      btn_filt  <= 1'b1;
    end else begin
      blink_cnt <= blink_cnt + 27'd1;
      if (btn_sample != btn_filt) begin
        if (db_cnt == DB_LAST) begin
          btn_filt <= btn_sample;
          db_cnt   <= '0;
        end else begin
          db_cnt <= db_cnt + DW'(1);
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign pressed = ~btn_filt;

  // Release is tested before the hold threshold so a coincident release is a short press.
  always_comb begin
    state_nx = state;
    mode_nx  = mode;
    case (state)
      IDLE:  if (pressed) state_nx = HELD;
      HELD:  begin
        if (!pressed) begin
          state_nx = IDLE;
          mode_nx  = mode + 2'd1;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nx = ARMED;
        end
      end
      ARMED: if (!pressed) state_nx = RESET;
      RESET: if (pulse_cnt == PULSE_LAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  function automatic logic [2:0] led_sel(state_t s, logic [1:0] m,
                                         logic b22, logic b24, logic b25);
    if (s == ARMED || s == RESET) return {3{~b22}};
    case (m)
      2'd0:    return {~b24, ~b25, 1'b1};
      2'd1:    return 3'b011;
      2'd2:    return 3'b101;
      default: return 3'b110;
    endcase
  endfunction

  always_ff @(posedge clk48 or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      mode       <= 2'd0;
      hold_cnt   <= '0;
      pulse_cnt  <= '0;
      rst_n      <= 1'b1;
      rgb_led0_r <= 1'b1;
      rgb_led0_g <= 1'b1;
      rgb_led0_b <= 1'b1;
    end else begin
      state <= state_nx;
      mode  <= mode_nx;
      if (state != HELD)               hold_cnt <= '0;
      else if (hold_cnt != HOLD_LAST)  hold_cnt <= hold_cnt + HW'(1);
      if (state != RESET)              pulse_cnt <= '0;
      else if (pulse_cnt != PULSE_LAST) pulse_cnt <= pulse_cnt + PW'(1);
      rst_n <= (state_nx != RESET);
      {rgb_led0_r, rgb_led0_g, rgb_led0_b} <=
        led_sel(state_nx, mode_nx, blink_cnt[22], blink_cnt[24], blink_cnt[25]);
    end
  end

endmodule

// File: tb/tb_btn_reset_ctrl.sv
// Directed bench for btn_reset_ctrl with shortened timing (debounce 4, hold 32, pulse 8).
module tb_btn_reset_ctrl;

  localparam int unsigned DB    = 4;
  localparam int unsigned HOLD  = 32;
  localparam int unsigned PULSE = 8;
`ifdef BTN_CTRL_SYNC2_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 5;
`endif

  logic       clk48 = 1'b0;
  logic       rst;
  logic       usr_btn;
  logic       rgb_led0_r, rgb_led0_g, rgb_led0_b;
  logic       rst_n;
  logic [1:0] mode;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk48 = ~clk48;

  btn_reset_ctrl #(
    .DEBOUNCE_CYCLES (DB),
    .HOLD_CYCLES     (HOLD),
    .RST_PULSE_CYCLES(PULSE)
  ) dut (
    .clk48     (clk48),
    .rst       (rst),
    .usr_btn   (usr_btn),
    .rgb_led0_r(rgb_led0_r),
    .rgb_led0_g(rgb_led0_g),
    .rgb_led0_b(rgb_led0_b),
    .rst_n     (rst_n),
    .mode      (mode)
  );

  task automatic tick();
    @(posedge clk48);
    #1;
  endtask

  task automatic test_reset();
    usr_btn = 1'b1;
    rst     = 1'b1;
    #23;
    n_checks++; if (rst_n !== 1'b1) begin n_fail++; $display("FAIL reset_rst_n: got %b want 1", rst_n); end
    n_checks++; if (mode !== 2'd0) begin n_fail++; $display("FAIL reset_mode: got %0d want 0", mode); end
    n_checks++; if ({rgb_led0_r, rgb_led0_g, rgb_led0_b} !== 3'b111) begin n_fail++;
      $display("FAIL reset_leds: got %b want 111", {rgb_led0_r, rgb_led0_g, rgb_led0_b}); end
    @(negedge clk48);
    rst = 1'b0;
    tick();
    n_checks++; if (rst_n !== 1'b1 || mode !== 2'd0) begin n_fail++;
      $display("FAIL post_reset: rst_n=%b mode=%0d want 1/0", rst_n, mode); end
    n_checks++; if ({rgb_led0_r, rgb_led0_g, rgb_led0_b} !== 3'b111) begin n_fail++;
      $display("FAIL post_reset_leds: got %b want 111", {rgb_led0_r, rgb_led0_g, rgb_led0_b}); end
    repeat (5) tick();
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 40; i++) begin
      usr_btn = ((i / 2) % 2) != 0;
      tick();
      n_checks++; if (dut.btn_filt !== 1'b1 || rst_n !== 1'b1) begin n_fail++;
        $display("FAIL bounce_cycle%0d: filt=%b rst_n=%b want 1/1", i, dut.btn_filt, rst_n); end
    end
    usr_btn = 1'b1;
    repeat (10) tick();
    n_checks++; if (mode !== 2'd0) begin n_fail++; $display("FAIL bounce_mode: got %0d want 0", mode); end
  endtask

  task automatic test_short_press();
    logic [1:0] exp_mode [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [2:0] exp_led  [4] = '{3'b011, 3'b101, 3'b110, 3'b111};
    for (int p = 0; p < 4; p++) begin
      usr_btn = 1'b0;
      repeat (10) tick();
      usr_btn = 1'b1;
      repeat (12) tick();
      n_checks++; if (mode !== exp_mode[p]) begin n_fail++;
        $display("FAIL short_press%0d_mode: got %0d want %0d", p, mode, exp_mode[p]); end
      n_checks++; if ({rgb_led0_r, rgb_led0_g, rgb_led0_b} !== exp_led[p]) begin n_fail++;
        $display("FAIL short_press%0d_leds: got %b want %b", p,
                 {rgb_led0_r, rgb_led0_g, rgb_led0_b}, exp_led[p]); end
    end
  endtask

  task automatic test_long_press();
    int edges;
    int low_cnt;
    usr_btn = 1'b0;
    repeat (10) tick();
    usr_btn = 1'b1;
    repeat (12) tick();
    n_checks++; if (mode !== 2'd1) begin n_fail++; $display("FAIL long_setup_mode: got %0d want 1", mode); end
    usr_btn = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      tick();
      if (k == LAT + 32) begin
        n_checks++; if ({rgb_led0_r, rgb_led0_g, rgb_led0_b} !== 3'b011) begin n_fail++;
          $display("FAIL long_before_armed: leds=%b want 011", {rgb_led0_r, rgb_led0_g, rgb_led0_b}); end
      end
      if (k == LAT + 33) begin
        n_checks++; if ({rgb_led0_r, rgb_led0_g, rgb_led0_b} !== 3'b111 || rst_n !== 1'b1) begin n_fail++;
          $display("FAIL long_armed: leds=%b rst_n=%b want 111/1",
                   {rgb_led0_r, rgb_led0_g, rgb_led0_b}, rst_n); end
      end
    end
    usr_btn = 1'b1;
    edges = 0;
    while (rst_n === 1'b1 && edges < 20) begin
      tick();
      edges++;
    end
    n_checks++; if (edges != LAT + 1) begin n_fail++;
      $display("FAIL long_pulse_start: rst_n low after %0d edges want %0d", edges, LAT + 1); end
    n_checks++; if ({rgb_led0_r, rgb_led0_g, rgb_led0_b} !== 3'b111) begin n_fail++;
      $display("FAIL long_pulse_leds: got %b want 111", {rgb_led0_r, rgb_led0_g, rgb_led0_b}); end
    low_cnt = 0;
    while (rst_n === 1'b0 && low_cnt < 20) begin
      low_cnt++;
      tick();
    end
    n_checks++; if (low_cnt != PULSE) begin n_fail++;
      $display("FAIL long_pulse_width: got %0d want %0d", low_cnt, PULSE); end
    n_checks++; if (mode !== 2'd1 || {rgb_led0_r, rgb_led0_g, rgb_led0_b} !== 3'b011) begin n_fail++;
      $display("FAIL long_after_pulse: mode=%0d leds=%b want 1/011", mode,
               {rgb_led0_r, rgb_led0_g, rgb_led0_b}); end
  endtask

  task automatic test_reset_mid_pulse();
    int edges;
    usr_btn = 1'b0;
    repeat (50) tick();
    usr_btn = 1'b1;
    edges = 0;
    while (rst_n === 1'b1 && edges < 20) begin
      tick();
      edges++;
    end
    repeat (3) tick();
    n_checks++; if (rst_n !== 1'b0) begin n_fail++; $display("FAIL mid_pulse_low: rst_n=%b want 0", rst_n); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (rst_n !== 1'b1) begin n_fail++; $display("FAIL mid_pulse_async: rst_n=%b want 1", rst_n); end
    n_checks++; if (mode !== 2'd0 || {rgb_led0_r, rgb_led0_g, rgb_led0_b} !== 3'b111) begin n_fail++;
      $display("FAIL mid_pulse_state: mode=%0d leds=%b want 0/111", mode,
               {rgb_led0_r, rgb_led0_g, rgb_led0_b}); end
    @(negedge clk48);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_checks++; if (rst_n !== 1'b1 || mode !== 2'd0) begin n_fail++;
        $display("FAIL mid_pulse_abort%0d: rst_n=%b mode=%0d want 1/0", i, rst_n, mode); end
    end
  endtask

  task automatic test_hold_race();
    int low_seen;
    usr_btn = 1'b0;
    repeat (32) tick();
    usr_btn = 1'b1;
    low_seen = 0;
    repeat (20) begin
      tick();
      if (rst_n !== 1'b1) low_seen++;
    end
    n_checks++; if (low_seen != 0) begin n_fail++;
      $display("FAIL race_rst_n: low for %0d cycles want 0", low_seen); end
    n_checks++; if (mode !== 2'd1) begin n_fail++; $display("FAIL race_mode: got %0d want 1", mode); end
    usr_btn = 1'b0;
    repeat (33) tick();
    usr_btn = 1'b1;
    low_seen = 0;
    repeat (25) begin
      tick();
      if (rst_n !== 1'b1) low_seen++;
    end
    n_checks++; if (low_seen != PULSE) begin n_fail++;
      $display("FAIL race_arm_pulse: low for %0d cycles want %0d", low_seen, PULSE); end
    n_checks++; if (mode !== 2'd1) begin n_fail++; $display("FAIL race_arm_mode: got %0d want 1", mode); end
  endtask

  task automatic test_latency();
    usr_btn = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      if (k == LAT - 1) begin
        n_checks++; if (dut.btn_filt !== 1'b1) begin n_fail++;
          $display("FAIL latency_press_early: filt=%b at edge %0d want 1", dut.btn_filt, k); end
      end
      if (k == LAT) begin
        n_checks++; if (dut.btn_filt !== 1'b0) begin n_fail++;
          $display("FAIL latency_press: filt=%b at edge %0d want 0", dut.btn_filt, k); end
      end
    end
    repeat (3) tick();
    usr_btn = 1'b1;
    for (int k = 1; k <= LAT; k++) begin
      tick();
      if (k == LAT - 1) begin
        n_checks++; if (dut.btn_filt !== 1'b0) begin n_fail++;
          $display("FAIL latency_release_early: filt=%b at edge %0d want 0", dut.btn_filt, k); end
      end
      if (k == LAT) begin
        n_checks++; if (dut.btn_filt !== 1'b1) begin n_fail++;
          $display("FAIL latency_release: filt=%b at edge %0d want 1", dut.btn_filt, k); end
      end
    end
    repeat (5) tick();
    n_checks++; if (mode !== 2'd2) begin n_fail++; $display("FAIL latency_mode: got %0d want 2", mode); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_bounce();
    test_short_press();
    test_long_press();
    test_reset_mid_pulse();
    test_hold_race();
    test_latency();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
